// File: rtl/adv_move_sequencer.sv
// Button-to-move sequencer for the adventure game: edge-qualified one-hot move pulses,
// route autoplay, game reset/restart sequencing. Optional move limit: ADV_MOVE_LIMIT_EN.
module adv_move_sequencer #(
  parameter logic [15:0] ROUTE      = 16'h0026,
  parameter int          ROUTE_LEN  = 3,
  parameter int          STEP_GAP   = 4,
  parameter int          RST_CYCLES = 2,
  parameter int          MAX_MOVES  = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_n,
  input  logic       btn_s,
  input  logic       btn_e,
  input  logic       btn_w,
  input  logic       auto_start,
  input  logic       restart,
  input  logic       win,
  input  logic       d,
  output logic       mv_n,
  output logic       mv_s,
  output logic       mv_e,
  output logic       mv_w,
  output logic       game_reset,
  output logic [1:0] state_o,
  output logic [7:0] move_cnt,
  output logic       timeout
);
  typedef enum logic [1:0] {S_RST = 2'd0, S_PLAY = 2'd1, S_AUTO = 2'd2, S_OVER = 2'd3} state_t;

`ifdef ADV_MOVE_LIMIT_EN
  localparam bit LIMIT_ON = 1'b1;
`else
  localparam bit LIMIT_ON = 1'b0;
`endif

  localparam logic [7:0]  MAX8     = 8'(MAX_MOVES);
  localparam logic [3:0]  RST_LAST = 4'(RST_CYCLES - 1);
  localparam logic [3:0]  GAP_LOAD = 4'(STEP_GAP - 1);
  localparam logic [3:0]  LEN4     = 4'(ROUTE_LEN);
  // Padded so the index one past the last move stays in range.
  localparam logic [17:0] ROUTE_X  = {2'b00, ROUTE};

  state_t     state;
  logic [3:0] hist, rst_cnt, gap, idx, mv;
  logic [3:0] btns;
  logic [1:0] code;
  logic       press, ended, limit, fire_btn, fire_auto;

  assign btns  = {btn_w, btn_e, btn_s, btn_n};
  assign code  = ROUTE_X[{idx, 1'b0} +: 2];
  assign press = $onehot(btns) && (hist == 4'd0);
  assign ended = win | d;
  assign limit = LIMIT_ON && (move_cnt >= MAX8) && !win;

  // Restart, game end and the move limit all pre-empt a move in the same cycle.
  assign fire_btn  = (state == S_PLAY) && press && !auto_start && !restart && !ended && !limit;
  assign fire_auto = (state == S_AUTO) && (idx != LEN4) && (gap == 4'd0) &&
                     !restart && !ended && !limit;

  assign {mv_w, mv_e, mv_s, mv_n} = mv;
  assign state_o = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_RST;
      game_reset <= 1'b1;
      rst_cnt    <= 4'd0;
      hist       <= 4'd0;
      mv         <= 4'd0;
      move_cnt   <= 8'd0;
      timeout    <= 1'b0;
      gap        <= 4'd0;
      idx        <= 4'd0;
    end else begin
      hist <= btns;
      mv   <= fire_btn ? btns : (fire_auto ? (4'b0001 << code) : 4'd0);
      if ((fire_btn || fire_auto) && move_cnt != 8'hFF) move_cnt <= move_cnt + 8'd1;

      if (restart && state != S_RST) begin
        state      <= S_RST;
        game_reset <= 1'b1;
        rst_cnt    <= 4'd0;
        move_cnt   <= 8'd0;
        timeout    <= 1'b0;
      end else begin
        case (state)
          S_RST: begin
            if (rst_cnt == RST_LAST) begin
              state      <= S_PLAY;
              game_reset <= 1'b0;
            end else begin
              rst_cnt <= rst_cnt + 4'd1;
            end
          end
          S_PLAY: begin
            if (ended) state <= S_OVER;
            else if (limit) begin
              timeout <= 1'b1;
              state   <= S_OVER;
            end else if (auto_start) begin
              state <= S_AUTO;
              idx   <= 4'd0;
              gap   <= GAP_LOAD;
            end
          end
          S_AUTO: begin
            if (ended) state <= S_OVER;
            else if (limit) begin
              timeout <= 1'b1;
              state   <= S_OVER;
            end else if (idx == LEN4) state <= S_PLAY;  // one cycle after the last move
            else if (gap == 4'd0) begin
              idx <= idx + 4'd1;
              gap <= GAP_LOAD;
            end else begin
              gap <= gap - 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule
